// File: rtl/neuron_seq_ctrl.sv
// Layer sequencer for one time-shared neuron (processing element + ReLU).
// For each output neuron it streams N_INPUTS weight/activation pairs and the
// bias from the on-chip RAMs into the neuron. It then waits for the ReLU
// result and writes that result to the output activation RAM at the neuron
// index. A layer ends with a one-cycle done pulse. If relu_done does not
// arrive within TIMEOUT cycles of the last pair, the layer aborts and the
// sticky err flag is set.
//
// Cycle timeline for one neuron (start accepted at the end of cycle 0):
//   cycles 1..N_INPUTS : FETCH. Addresses and mem_rd_en are on the RAM ports.
//   cycles 2..N_INPUTS+1 : pairs are on w/x. The head and the bias are in
//                          cycle 2. Cycle N_INPUTS+1 is DRAIN.
//   WAIT_DONE : lasts until relu_done arrives or the timeout expires.
//   WRITE : one cycle with res_we high.
// The RAMs return read data for the address currently on the bus, and the
// controller registers that data onto the neuron ports. Each pair therefore
// reaches the neuron one cycle after its address.
module neuron_seq_ctrl #(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 10,
  parameter int W_AW      = 13,
  parameter int X_AW      = 10,
  parameter int N_AW      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [W_AW-1:0] w_addr,
  output logic [X_AW-1:0] x_addr,
  output logic [N_AW-1:0] b_addr,
  output logic            mem_rd_en,
  input  logic [31:0]     w_rdata,
  input  logic [31:0]     x_rdata,
  input  logic [31:0]     b_rdata,
  output logic [31:0]     w_ctrl2neuron,
  output logic [31:0]     x_ctrl2neuron,
  output logic [31:0]     b_ctrl2neuron,
  output logic            head_ctrl2neuron,
  input  logic [31:0]     relu_out_neuron2ctrl,
  input  logic            relu_done_neuron2ctrl,
  output logic            res_we,
  output logic [N_AW-1:0] res_addr,
  output logic [31:0]     res_data
);

  // Counter widths. Each counter keeps at least one bit so that the
  // degenerate N_INPUTS=1 / N_NEURONS=1 cases still elaborate.
  localparam int I_W = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1;
  localparam int N_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int T_W = $clog2(TIMEOUT + 1);

  localparam logic [I_W-1:0]  I_LAST = I_W'(N_INPUTS - 1);
  localparam logic [N_W-1:0]  N_LAST = N_W'(N_NEURONS - 1);
  localparam logic [T_W-1:0]  T_LAST = T_W'(TIMEOUT - 1);
  localparam logic [W_AW-1:0] W_STEP = W_AW'(N_INPUTS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_DONE,
    WRITE
  } state_t;

  state_t          state;
  logic [I_W-1:0]  i;      // input index of the address on the bus
  logic [N_W-1:0]  n;      // current output neuron
  logic [W_AW-1:0] wbase;  // first weight address of neuron n (running sum, no multiplier)
  logic [T_W-1:0]  tcnt;   // cycles since the last pair left the controller

  // Sequencer FSM with all outputs registered. done, res_we and head are
  // single-cycle strobes: each defaults to 0 and is raised only where needed.
  // NOTE: every state element here uses non-blocking assignment. The FSM
  // then reads the pre-edge values of i, n and wbase throughout the block,
  // independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      i                <= '0;
      n                <= '0;
      wbase            <= '0;
      tcnt             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      w_addr           <= '0;
      x_addr           <= '0;
      b_addr           <= '0;
      mem_rd_en        <= 1'b0;
      w_ctrl2neuron    <= '0;
      x_ctrl2neuron    <= '0;
      b_ctrl2neuron    <= '0;
      head_ctrl2neuron <= 1'b0;
      res_we           <= 1'b0;
      res_addr         <= '0;
      res_data         <= '0;
    end else begin
      done             <= 1'b0;
      res_we           <= 1'b0;
      head_ctrl2neuron <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            i         <= '0;
            n         <= '0;
            wbase     <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            w_addr    <= '0;
            x_addr    <= '0;
            b_addr    <= '0;
          end
        end

        FETCH: begin
          // The RAM data for address i moves to the neuron ports in the
          // next cycle. The bias is latched with the first pair and then
          // held until the next head.
          w_ctrl2neuron <= w_rdata;
          x_ctrl2neuron <= x_rdata;
          if (i == '0) begin
            head_ctrl2neuron <= 1'b1;
            b_ctrl2neuron    <= b_rdata;
          end
          if (i == I_LAST) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
            tcnt      <= '0;
          end else begin
            i      <= i + 1'b1;
            w_addr <= wbase + W_AW'(i) + W_AW'(1);
            x_addr <= X_AW'(i) + X_AW'(1);
          end
        end

        DRAIN: begin
          // The last pair is on the ports during this cycle. Blank w/x
          // after it so that the neuron sees zeros outside the stream.
          w_ctrl2neuron <= '0;
          x_ctrl2neuron <= '0;
          tcnt          <= tcnt + 1'b1;
          state         <= WAIT_DONE;
        end

        WAIT_DONE: begin
          // If relu_done and timeout expiry land in the same cycle, the
          // result is taken.
          if (relu_done_neuron2ctrl) begin
            res_we   <= 1'b1;
            res_addr <= N_AW'(n);
            res_data <= relu_out_neuron2ctrl;
            state    <= WRITE;
          end else if (tcnt >= T_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WRITE: begin
          if (n == N_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            // The first address of the next neuron goes out in the cycle
            // right after the write, so the neurons run back to back.
            n         <= n + 1'b1;
            wbase     <= wbase + W_STEP;
            i         <= '0;
            mem_rd_en <= 1'b1;
            w_addr    <= wbase + W_STEP;
            x_addr    <= '0;
            b_addr    <= N_AW'(n) + N_AW'(1);
            state     <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench for neuron_seq_ctrl.
// Instance dut uses N_INPUTS=4, N_NEURONS=3, TIMEOUT=8. A behavioural neuron
// drives it and checks every pair against the RAM images.
// Instance dut1 uses N_INPUTS=1, N_NEURONS=2. It is driven by hand and covers
// the case where the head and the last pair fall in the same cycle.
// Cycle numbers are counted from the accepting edge of start: the cycle
// after that edge is cycle 1.
module tb_neuron_seq_ctrl;

  localparam int NI = 4;
  localparam int NN = 3;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  int base = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance with N_INPUTS=4 ----------------
  logic        busy, done, err, mem_rd_en, head, res_we, relu_done;
  logic [3:0]  w_addr;
  logic [1:0]  x_addr, b_addr, res_addr;
  logic [31:0] w_rdata, x_rdata, b_rdata, w_n, x_n, b_n, relu_out, res_data;

  logic [31:0] wmem [16];
  logic [31:0] xmem [4];
  logic [31:0] bmem [4];
  assign w_rdata = wmem[w_addr];
  assign x_rdata = xmem[x_addr];
  assign b_rdata = bmem[b_addr];

  neuron_seq_ctrl #(
    .N_INPUTS(NI), .N_NEURONS(NN), .W_AW(4), .X_AW(2), .N_AW(2), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .err(err),
    .w_addr(w_addr), .x_addr(x_addr), .b_addr(b_addr), .mem_rd_en(mem_rd_en),
    .w_rdata(w_rdata), .x_rdata(x_rdata), .b_rdata(b_rdata),
    .w_ctrl2neuron(w_n), .x_ctrl2neuron(x_n), .b_ctrl2neuron(b_n),
    .head_ctrl2neuron(head),
    .relu_out_neuron2ctrl(relu_out), .relu_done_neuron2ctrl(relu_done),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  // Behavioural neuron: per-neuron latency, result value and a hang flag.
  int          lat [3];
  logic [31:0] val [3];
  bit          hang [3];
  int          m_pcnt = 0, m_n = 0, m_heads = 0, m_fire = -1, m_fire_n = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_out = '0;
  logic        spur_done = 1'b0;
  logic [31:0] spur_out = '0;
  assign relu_done = m_done | spur_done;
  assign relu_out  = spur_done ? spur_out : m_out;

  always @(negedge clock) begin
    m_done = 1'b0;
    if (reset) begin
      m_pcnt = 0;
      m_fire = -1;
    end else begin
      if (m_fire == cyc) begin
        m_done = 1'b1;
        m_out  = val[m_fire_n];
        m_fire = -1;
      end
      if (head) begin
        m_n = m_heads;
        m_heads++;
        m_pcnt = 0;
        check("head_b", b_n, bmem[m_n]);
      end
      if (head || m_pcnt != 0) begin
        check("pair_w", w_n, wmem[m_n*NI + m_pcnt]);
        check("pair_x", x_n, xmem[m_pcnt]);
        m_pcnt++;
        if (m_pcnt == NI) begin
          m_pcnt = 0;
          if (!hang[m_n]) begin
            m_fire   = cyc + lat[m_n];
            m_fire_n = m_n;
          end
        end
      end else begin
        check("gap_wx", {w_n, x_n}, 64'd0);
      end
    end
  end

  // Event log for the instance with N_INPUTS=4.
  int          head_q[$], wa_q[$], wr_cyc_q[$], wr_addr_q[$], done_q[$];
  logic [31:0] wr_data_q[$];
  always @(negedge clock) begin
    if (!reset) begin
      if (head)      head_q.push_back(cyc - base);
      if (mem_rd_en) wa_q.push_back(int'(w_addr));
      if (done)      done_q.push_back(cyc - base);
      if (res_we) begin
        wr_cyc_q.push_back(cyc - base);
        wr_addr_q.push_back(int'(res_addr));
        wr_data_q.push_back(res_data);
      end
    end
  end

  // ---------------- instance with N_INPUTS=1 ----------------
  logic        u1_start = 1'b0;
  logic        u1_busy, u1_done, u1_err, u1_mem_rd_en, u1_head, u1_res_we;
  logic        u1_relu_done = 1'b0;
  logic [31:0] u1_relu_out = '0;
  logic [0:0]  u1_w_addr, u1_x_addr, u1_b_addr, u1_res_addr;
  logic [31:0] u1_w_rdata, u1_x_rdata, u1_b_rdata, u1_w, u1_x, u1_b, u1_res_data;
  logic [31:0] w1mem [2];
  logic [31:0] x1mem [2];
  logic [31:0] b1mem [2];
  assign u1_w_rdata = w1mem[u1_w_addr];
  assign u1_x_rdata = x1mem[u1_x_addr];
  assign u1_b_rdata = b1mem[u1_b_addr];

  neuron_seq_ctrl #(
    .N_INPUTS(1), .N_NEURONS(2), .W_AW(1), .X_AW(1), .N_AW(1), .TIMEOUT(TO)
  ) dut1 (
    .clock(clock), .reset(reset), .start(u1_start),
    .busy(u1_busy), .done(u1_done), .err(u1_err),
    .w_addr(u1_w_addr), .x_addr(u1_x_addr), .b_addr(u1_b_addr), .mem_rd_en(u1_mem_rd_en),
    .w_rdata(u1_w_rdata), .x_rdata(u1_x_rdata), .b_rdata(u1_b_rdata),
    .w_ctrl2neuron(u1_w), .x_ctrl2neuron(u1_x), .b_ctrl2neuron(u1_b),
    .head_ctrl2neuron(u1_head),
    .relu_out_neuron2ctrl(u1_relu_out), .relu_done_neuron2ctrl(u1_relu_done),
    .res_we(u1_res_we), .res_addr(u1_res_addr), .res_data(u1_res_data)
  );

  // ---------------- helpers ----------------
  int          e_head [3];
  int          e_wr   [3];
  logic [31:0] e_dat  [3];

  task automatic start_layer(input int which);
    @(negedge clock);
    head_q.delete(); wa_q.delete(); wr_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); done_q.delete();
    m_heads = 0;
    m_pcnt  = 0;
    m_fire  = -1;
    if (which == 0) start = 1'b1; else u1_start = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    u1_start = 1'b0;
    base     = cyc - 1;
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_ctl"}, {busy, done, err, mem_rd_en, head, res_we}, 64'd0);
    check({tag, "_addr"}, {w_addr, x_addr, b_addr, res_addr}, 64'd0);
    check({tag, "_data"}, {w_n | x_n, b_n | res_data}, 64'd0);
  endtask

  task automatic check_heads(input string tag);
    check({tag, "_nhead"}, head_q.size(), 3);
    for (int k = 0; k < head_q.size() && k < 3; k++)
      check({tag, "_head_cyc"}, head_q[k], e_head[k]);
  endtask

  task automatic check_writes(input string tag, input int nwr);
    check({tag, "_nwr"}, wr_cyc_q.size(), nwr);
    for (int k = 0; k < wr_cyc_q.size() && k < nwr; k++) begin
      check({tag, "_wr_cyc"}, wr_cyc_q[k], e_wr[k]);
      check({tag, "_wr_addr"}, wr_addr_q[k], k);
      check({tag, "_wr_data"}, wr_data_q[k], e_dat[k]);
    end
  endtask

  task automatic check_done(input string tag, input int exp_cyc);
    check({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, "_done_cyc"}, done_q[0], exp_cyc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < 16; k++) wmem[k] = 32'h1000_0000 + 32'(k * 3 + 1);
    for (int k = 0; k < 4; k++) begin
      xmem[k] = 32'h2000_0000 + 32'(k * 5 + 2);
      bmem[k] = 32'h3000_0000 + 32'(k + 9);
    end
    w1mem = '{32'hAAAA_0001, 32'hAAAA_0002};
    x1mem = '{32'hBBBB_0001, 32'hBBBB_0002};
    b1mem = '{32'hCCCC_0001, 32'hCCCC_0002};
    lat  = '{3, 3, 3};
    val  = '{32'd7, 32'd107, 32'd207};
    hang = '{1'b0, 1'b0, 1'b0};

    // Reset, then stay idle for 20 cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int r = 0; r < 20; r++) begin
      @(negedge clock);
      expect_quiet("idle");
      check("idle_u1", {u1_busy, u1_done, u1_err, u1_mem_rd_en, u1_res_we}, 64'd0);
    end

    // Basic layer. It includes a spurious relu_done during the FETCH of
    // neuron 1 and a start pulse while the layer is busy.
    start_layer(0);
    for (int r = 1; r <= 32; r++) begin
      @(negedge clock);
      if (r == 1)  check("basic_first_addr", {mem_rd_en, busy, err}, 64'b110);
      if (r == 27) check("basic_busy_last", {done, busy}, 64'b01);
      if (r == 28) check("basic_done", {done, busy}, 64'b10);
      if (r == 29) check("basic_after", {done, busy}, 64'b00);
      spur_done = (r == 11);
      spur_out  = 32'hDEAD_BEEF;
      start     = (r == 14);
    end
    start = 1'b0;
    e_head = '{2, 11, 20};
    e_wr   = '{9, 18, 27};
    e_dat  = '{32'd7, 32'd107, 32'd207};
    check_heads("basic");
    check_writes("basic", 3);
    check_done("basic", 28);
    check("basic_nrd", wa_q.size(), 12);
    for (int k = 0; k < wa_q.size() && k < 12; k++) check("basic_waddr", wa_q[k], k);

    // ReLU pass-through of the extreme values. Neuron 1 answers in the
    // same cycle that the timeout would fire.
    lat = '{2, 7, 1};
    val = '{32'h0000_0000, 32'h7FFF_FFFF, 32'd5};
    start_layer(0);
    for (int r = 1; r <= 32; r++) @(negedge clock);
    e_head = '{2, 10, 23};
    e_wr   = '{8, 21, 28};
    e_dat  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'd5};
    check_heads("relu");
    check_writes("relu", 3);
    check_done("relu", 29);
    check("relu_err", err, 1'b0);

    // Timeout. Neuron 1 never answers: its DRAIN is cycle 14, so the abort
    // is visible in cycle 22.
    lat  = '{3, 3, 3};
    val  = '{32'd7, 32'd107, 32'd207};
    hang = '{1'b0, 1'b1, 1'b0};
    start_layer(0);
    for (int r = 1; r <= 26; r++) begin
      @(negedge clock);
      if (r == 21) check("to_before", {err, busy, done}, 64'b010);
      if (r == 22) check("to_abort", {err, busy, done}, 64'b101);
      if (r == 26) check("to_sticky", {err, busy, done}, 64'b100);
    end
    e_wr  = '{9, 0, 0};
    e_dat = '{32'd7, 32'd0, 32'd0};
    check_writes("to", 1);
    check_done("to", 22);

    // Next start clears err. Reset arrives during neuron 1 FETCH at i=2.
    hang = '{1'b0, 1'b0, 1'b0};
    start_layer(0);
    for (int r = 1; r <= 14; r++) begin
      @(negedge clock);
      if (r == 1)  check("rst_err_clear", {err, busy}, 64'b01);
      if (r == 12) check("rst_at_i2", {mem_rd_en, w_addr}, {59'd0, 1'b1, 4'd6});
      if (r == 13) expect_quiet("rst");
      if (r == 12) reset = 1'b1;
      if (r == 14) reset = 1'b0;
    end
    check_writes("rst", 1);
    start_layer(0);
    @(negedge clock);
    check("rerun_first", {mem_rd_en, w_addr, x_addr, b_addr}, {55'd0, 1'b1, 4'd0, 2'd0, 2'd0});
    for (int r = 2; r <= 32; r++) @(negedge clock);
    e_head = '{2, 11, 20};
    e_wr   = '{9, 18, 27};
    e_dat  = '{32'd7, 32'd107, 32'd207};
    check_heads("rerun");
    check_writes("rerun", 3);
    check_done("rerun", 28);

    // N_INPUTS=1: the head and the only pair share one cycle.
    start_layer(1);
    for (int r = 1; r <= 10; r++) begin
      @(negedge clock);
      case (r)
        1: check("n1_fetch0", {u1_mem_rd_en, u1_w_addr, u1_x_addr, u1_b_addr}, 64'b1000);
        2: begin
          check("n1_head0", {u1_head, u1_mem_rd_en}, 64'b10);
          check("n1_w0", u1_w, w1mem[0]);
          check("n1_x0", u1_x, x1mem[0]);
          check("n1_b0", u1_b, b1mem[0]);
        end
        3: begin
          check("n1_gap", {u1_head, u1_w | u1_x}, 64'd0);
          u1_relu_done = 1'b1;
          u1_relu_out  = 32'd55;
        end
        4: begin
          u1_relu_done = 1'b0;
          check("n1_wr0", {u1_res_we, u1_res_addr}, 64'b10);
          check("n1_wr0_data", u1_res_data, 32'd55);
        end
        5: check("n1_fetch1", {u1_mem_rd_en, u1_w_addr, u1_x_addr, u1_b_addr}, 64'b1101);
        6: begin
          check("n1_head1", u1_head, 1'b1);
          check("n1_w1", u1_w, w1mem[1]);
          check("n1_x1", u1_x, x1mem[0]);
          check("n1_b1", u1_b, b1mem[1]);
        end
        7: begin
          u1_relu_done = 1'b1;
          u1_relu_out  = 32'd66;
        end
        8: begin
          u1_relu_done = 1'b0;
          check("n1_wr1", {u1_res_we, u1_res_addr}, 64'b11);
          check("n1_wr1_data", u1_res_data, 32'd66);
        end
        9:  check("n1_done", {u1_done, u1_busy, u1_err}, 64'b100);
        10: check("n1_after", {u1_done, u1_busy}, 64'b00);
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
- Layer sequencer for a single time-shared neuron (processing element followed by ReLU).
- On each start it loops over N_NEURONS output neurons. For each one it streams N_INPUTS weight/activation pairs and the bias from on-chip memories into the neuron, waits for the ReLU result, and writes that result to the output activation memory.
- Sits between the weight/bias/activation RAMs and the neuron; it is the only driver of the neuron's w/x/b/head inputs.

Parameters:
- N_INPUTS, 784, pairs per neuron (>=1).
- N_NEURONS, 10, output neurons per layer (>=1).
- W_AW, 13, weight RAM address width (>= clog2(N_INPUTS*N_NEURONS)).
- X_AW, 10, input activation RAM address width.
- N_AW, 4, bias RAM / result RAM address width.
- TIMEOUT, 64, max cycles to wait for relu_done after the last pair.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the layer completes or aborts.
- err  out  1  sticky timeout flag; cleared on the next accepted start or on reset.
- w_addr  out  W_AW  weight RAM address.
- x_addr  out  X_AW  activation RAM address.
- b_addr  out  N_AW  bias RAM address.
- mem_rd_en  out  1  read strobe shared by the weight, activation and bias RAMs.
- w_rdata  in  32  weight data, valid 1 cycle after address.
- x_rdata  in  32  activation data, valid 1 cycle after address.
- b_rdata  in  32  bias data, valid 1 cycle after address.
- w_ctrl2neuron  out  32  weight to neuron.
- x_ctrl2neuron  out  32  activation to neuron.
- b_ctrl2neuron  out  32  bias to neuron.
- head_ctrl2neuron  out  1  first-pair marker.
- relu_out_neuron2ctrl  in  32  neuron result.
- relu_done_neuron2ctrl  in  1  result-valid pulse.
- res_we  out  1  result RAM write enable.
- res_addr  out  N_AW  result RAM address (= neuron index).
- res_data  out  32  result RAM write data.

Behaviour:
- States: IDLE, FETCH, DRAIN, WAIT_DONE, WRITE. All outputs are registered.
- Reset state: IDLE; every output is 0; counters i (input index), n (neuron index) and wbase are 0.
- IDLE:
  - start=1 -> FETCH, with i=0, n=0, wbase=0, err cleared, busy=1 from the next cycle.
  - start while busy is ignored.
- FETCH (N_INPUTS cycles):
  - Each cycle: mem_rd_en=1, w_addr=wbase+i, x_addr=i, b_addr=n.
  - i increments each cycle; when i==N_INPUTS-1 -> DRAIN.
  - No multiplier: wbase advances by N_INPUTS per neuron.
- Neuron data path:
  - One cycle after each FETCH cycle (and in DRAIN), the RAM data is registered to the w/x/b outputs.
  - head_ctrl2neuron=1 only in the cycle carrying pair i=0; b_ctrl2neuron is valid in that same cycle and holds until the next head.
  - Pairs are contiguous, one per cycle, with no bubbles.
  - Outside the stream, w and x are driven 0 and head is 0.
- DRAIN (1 cycle): presents the last pair; mem_rd_en=0 -> WAIT_DONE. The timeout counter is cleared on entry.
- WAIT_DONE:
  - relu_done=1 -> capture relu_out -> WRITE.
  - Timeout counter reaches TIMEOUT -> err=1, done pulse, -> IDLE (layer aborted, no write).
  - relu_done seen in any state other than WAIT_DONE is ignored.
- WRITE (1 cycle):
  - res_we=1, res_addr=n, res_data=captured result.
  - If n==N_NEURONS-1: done=1 next cycle, busy=0 next cycle -> IDLE.
  - Otherwise: n+=1, wbase+=N_INPUTS, i=0 -> FETCH.
- Timing per neuron: N_INPUTS+1 cycles of stream, plus the neuron latency, plus 1 write cycle.
- Timing from start: start at cycle 0 -> first address at cycle 1 -> head at cycle 2 -> last pair at cycle N_INPUTS+1.
- N_INPUTS=1: FETCH lasts 1 cycle; head and the last pair are the same cycle.
- Reset mid-operation (any state): return to IDLE next cycle; all outputs 0; a pending write is dropped.
- relu_done and timeout expiry in the same cycle: relu_done wins.

Test Plan:
- Reset/idle: after reset, hold start=0 for 20 cycles -> all outputs 0, busy=0, no mem_rd_en.
- Basic layer: N_INPUTS=4, N_NEURONS=3; behavioural neuron returns relu_done 3 cycles after the last pair with value n*100+7.
  - head at cycles 2, then each subsequent neuron start.
  - w_addr sequences 0..3, 4..7, 8..11.
  - res_we writes (0,7), (1,107), (2,207).
  - Single done pulse; busy low afterwards.
- ReLU pass-through: neuron returns 0 for one neuron and 0x7FFFFFFF for another -> res_data matches exactly; no pair gaps on x/w.
- Timeout: TIMEOUT=8; the neuron never asserts relu_done for neuron 1 -> err=1 and done pulse 8 cycles after DRAIN; only neuron 0 is written. A following start clears err.
- Reset mid-stream: assert reset during neuron 1 FETCH at i=2 -> next cycle IDLE, outputs 0. A new start re-runs from n=0, w_addr=0.
- Edge/ignored events: N_INPUTS=1 -> head and the single pair coincide. A spurious relu_done during FETCH causes no write. Start pulsed while busy has no effect.
